// File: rtl/frv_asi_seq_pkg.sv
// frv_asi_seq_pkg: uop field constants and AES/SHA-256 datapath helper functions
package frv_asi_seq_pkg;
  typedef enum logic [1:0] {ASI_NONE = 2'b00, ASI_AES = 2'b01, ASI_SHA2 = 2'b10, ASI_RSVD = 2'b11} asi_cls_e;
  localparam int ASI_DEC = 0;
  localparam int ASI_ROT = 1;
  localparam int ASI_MIX = 2;
  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      r = r ^ (b[i] ? p : 8'h00);
      p = xtime(p);
    end
    return r;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rol8(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox_fwd(logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rol8(v, 1) ^ rol8(v, 2) ^ rol8(v, 3) ^ rol8(v, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] sbox_inv(logic [7:0] x);
    return gf_inv(rol8(x, 1) ^ rol8(x, 3) ^ rol8(x, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] mix_col(logic [31:0] w, logic dec);
    logic [7:0] a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = w[8*i +: 8];
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = dec ? gf_mul(a[i], 8'h0e) ^ gf_mul(a[(i+1)%4], 8'h0b) ^ gf_mul(a[(i+2)%4], 8'h0d) ^ gf_mul(a[(i+3)%4], 8'h09)
                        : xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    return r;
  endfunction
  function automatic logic [31:0] ror32(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sha_sig(logic [31:0] x, logic [1:0] s);
    return s == 2'd0 ? ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3) :
           s == 2'd1 ? ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10) :
           s == 2'd2 ? ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22) :
                       ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
  endfunction
endpackage

// File: rtl/xc_aes_sbox.sv
// xc_aes_sbox: single-byte AES forward/inverse S-box
module xc_aes_sbox
  import frv_asi_seq_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_dec,
  output logic [7:0] o_byte
);
  assign o_byte = i_dec ? sbox_inv(i_byte) : sbox_fwd(i_byte);
endmodule

// File: rtl/frv_asi_seq.sv
// frv_asi_seq: multi-cycle AES/SHA-256 instruction unit with lane-multiplexed S-boxes
module frv_asi_seq
  import frv_asi_seq_pkg::*;
#(
  parameter int SBOX_LANES = 4,
  parameter bit CLASS_AES  = 1'b1,
  parameter bit CLASS_SHA2 = 1'b1,
  parameter int UOP_W      = 5
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             asi_valid,
  output logic             asi_ready,
  output logic             asi_busy,
  input  logic             asi_flush,
  input  logic [UOP_W-1:0] asi_uop,
  input  logic [31:0]      asi_rs1,
  input  logic [31:0]      asi_rs2,
  output logic [31:0]      asi_result
);
  localparam int N = 4 / SBOX_LANES;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  state_e      r_state, w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_w, r_res, w_imm, w_sub_res;
  logic        r_dec, r_rot;
  asi_cls_e    w_cls;
  logic        w_aes, w_sha, w_sub, w_acc, w_last;
  logic [1:0]  w_idx [SBOX_LANES];
  logic [7:0]  w_sb  [SBOX_LANES];
  assign w_cls  = asi_cls_e'(asi_uop[4:3]);
  assign w_aes  = CLASS_AES && w_cls == ASI_AES;
  assign w_sha  = CLASS_SHA2 && w_cls == ASI_SHA2;
  assign w_sub  = w_aes && !asi_uop[ASI_MIX];
  assign w_acc  = r_state == S_IDLE && asi_valid && !asi_flush;
  assign w_last = r_cnt == 2'(N - 1);
  assign w_imm  = w_aes ? mix_col(asi_rs1, asi_uop[ASI_DEC]) ^ asi_rs2 :
                  w_sha ? sha_sig(asi_rs1, asi_uop[1:0]) : 32'h0;
  // each BUSY cycle covers the next SBOX_LANES bytes of the latched word
  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    assign w_idx[l] = 2'(32'(r_cnt) * SBOX_LANES + l);
    xc_aes_sbox u_sbox (.i_byte(r_w[{w_idx[l], 3'b000} +: 8]), .i_dec(r_dec), .o_byte(w_sb[l]));
  end
  always_comb begin
    w_sub_res = r_res;
    for (int k = 0; k < SBOX_LANES; k++) w_sub_res[{w_idx[k], 3'b000} +: 8] = w_sb[k];
  end
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) r_state <= S_IDLE;
    else           r_state <= w_next;
  always_comb
    w_next = asi_flush            ? S_IDLE :
             r_state == S_IDLE    ? (asi_valid ? (w_sub ? S_BUSY : S_DONE) : S_IDLE) :
             r_state == S_BUSY    ? (!asi_valid ? S_IDLE : w_last ? S_DONE : S_BUSY) :
                                    S_IDLE;
  always_comb begin
    asi_ready  = r_state == S_DONE && asi_valid && !asi_flush;
    asi_busy   = r_state != S_IDLE;
    asi_result = !asi_ready ? 32'h0 : r_rot ? {r_res[7:0], r_res[31:8]} : r_res;
  end
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      r_cnt <= '0;
      r_res <= '0;
      r_w   <= '0;
      r_dec <= 1'b0;
      r_rot <= 1'b0;
    end else if (asi_flush) begin
      r_cnt <= '0;
      r_res <= '0;
    end else if (w_acc) begin
      r_cnt <= '0;
      r_w   <= asi_rs1 ^ asi_rs2;
      r_dec <= asi_uop[ASI_DEC];
      r_rot <= w_aes && asi_uop[ASI_ROT];
      r_res <= w_sub ? 32'h0 : w_imm;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 2'd1;
      r_res <= w_sub_res;
    end
endmodule

// File: doc/frv_asi_seq.md
Name: frv_asi_seq

Overview:
- Multi-cycle, parametrised successor to the combinational algorithm-specific-instruction unit. It sits in the same execute-stage slot and uses the same valid/ready stage handshake.
- Executes AES SubBytes (fused AddRoundKey, optional rotate), AES MixColumn and the four SHA-256 sigma functions.
- The S-box datapath is time-multiplexed over a configurable number of lanes, trading area for latency.
- Results are registered, and the unit supports flush and pipeline-kill mid-operation.

Parameters:
- SBOX_LANES, 4, number of parallel S-boxes; legal values 1, 2, 4. AESSUB takes N = 4/SBOX_LANES busy cycles.
- CLASS_AES, 1, enables the AES uops; when 0, AES uops complete with result 0.
- CLASS_SHA2, 1, enables the SHA2 uops; when 0, SHA2 uops complete with result 0.
- UOP_W, 5, width of asi_uop.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  reset; asynchronous, active-low
- asi_valid  in  1  instruction present; held stable with its operands until asi_ready
- asi_ready  out  1  one-cycle pulse: instruction complete, asi_result valid
- asi_busy  out  1  FSM not in IDLE
- asi_flush  in  1  synchronous abort of any in-flight operation
- asi_uop  in  UOP_W  operation select
- asi_rs1  in  32  source operand 1
- asi_rs2  in  32  source operand 2
- asi_result  out  32  result; zero whenever asi_ready is low

Behaviour:
- Reset: state IDLE, counter 0, result register 0, asi_ready 0, asi_busy 0.
- Uop encoding:
  - [4:3]=01 is AES: bit2 selects mix, bit0 selects decrypt, bit1 selects rot.
  - [4:3]=10 is SHA2: [1:0] selects s0..s3.
  - Any other encoding is unsupported.
- FSM states:
  - IDLE:
    - asi_valid && !asi_flush latches uop, rs1 and rs2.
    - AESSUB goes to BUSY with counter = 0.
    - Every other uop (SHA2, AESMIX, unsupported, disabled class) computes its result into the result register and goes to DONE.
  - BUSY:
    - Applies the forward or inverse S-box to SBOX_LANES bytes of W = rs1 ^ rs2, starting at byte index counter*SBOX_LANES, and writes them into the result register.
    - Counter increments each cycle; when counter == N-1, the FSM goes to DONE.
  - DONE:
    - asi_ready = 1 and asi_result = the result register (rotated right by 8 if rot) for exactly one cycle.
    - The FSM then returns to IDLE. An instruction presented in the following cycle is accepted normally (back-to-back, no bubble beyond DONE).
- Latency, counted from the accept cycle t:
  - SHA2, AESMIX, unsupported: asi_ready at t+1.
  - AESSUB: asi_ready at t+N+1, i.e. t+2, t+3 or t+5 for 4, 2 or 1 lanes.
- Datapath functions:
  - AESMIX: result = MixColumn(rs1) ^ rs2, or InvMixColumn when decrypt. Byte 0 = row 0.
  - SHA2 s0 = ror7 ^ ror18 ^ shr3.
  - SHA2 s1 = ror17 ^ ror19 ^ shr10.
  - SHA2 s2 = ror2 ^ ror13 ^ ror22.
  - SHA2 s3 = ror6 ^ ror11 ^ ror25.
- Flush: asi_flush in any state forces IDLE next cycle, clears counter and result register, and suppresses asi_ready in that cycle. Flush beats a simultaneous asi_valid in IDLE.
- Kill: asi_valid low while in BUSY or DONE aborts to IDLE next cycle with no asi_ready pulse.
- Operands are captured at accept; changes to rs1/rs2 while busy are ignored.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately.

Decomposition:
- Uop class/field constants (ASI_AES, ASI_SHA2, bit positions) go in the shared frv_common.vh header.
- FSM state encodings stay local.
- One sub-module, xc_aes_sbox: byte in, enc/dec select, byte out. Instantiated SBOX_LANES times.

Test Plan:
- AESSUB enc, rs1=0x00010253, rs2=0, SBOX_LANES=4 -> asi_ready at t+2, result 0x637C77ED. With rot -> 0xED637C77. With SBOX_LANES=1 -> same value, asi_ready at t+5, asi_busy high t+1..t+5.
- AESSUB dec, rs1=0x63636363, rs2=0x63636363 -> W=0 -> result 0x52525252. Dec of rs1=0x637C77ED, rs2=0 -> 0x00010253.
- AESMIX enc, rs1=0x455313DB, rs2=0 -> 0xBCA14D8E. Dec of that with rs2=0 -> 0x455313DB. Enc with rs2=0xFFFFFFFF -> 0x435EB271.
- SHA2 s0, rs1=0x00000001 -> 0x02004000 at t+1. Back-to-back s0 then s1 on rs1=1 -> pulses at t+1 and t+3, second result 0x0000A000.
- asi_flush asserted in the 2nd BUSY cycle (SBOX_LANES=1) -> no asi_ready, IDLE next cycle, next SHA2 uop completes normally. asi_valid dropped in BUSY -> same abort behaviour.
- Unsupported uop class 11, or CLASS_SHA2=0 with a SHA2 uop -> asi_ready at t+1, result 0x00000000. g_resetn pulsed low mid-BUSY -> asi_ready and asi_busy low immediately.
